clamp_slew_mc: RTL and testbench

- Multi-channel successor to the single-channel fixed-point clamp.
- Applies runtime lower and upper bounds to N signed fixed-point channels, with an optional per-channel slew-rate limit.
- Keeps per-channel saturation statistics.
- Sits between real-valued model blocks. All channels share one fixed-point format (value = code * 2^EXP), so no format alignment is done inside the block.

---
 rtl/clamp_slew_mc.sv | 128 ++++++++++++
 tb/tb_clamp_slew_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clamp_slew_mc.sv
// Multi-channel signed fixed-point clamp with optional per-channel slew limiting and
// saturating per-channel clamp statistics. One cycle of latency, shared format for all channels.
module clamp_slew_mc #(
    parameter int N   = 2,
    parameter int W   = 16,
    parameter int EXP = -8,
    parameter int CW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [1:0]      mode,
    input  logic [W-1:0]    lo,
    input  logic [W-1:0]    hi,
    input  logic [W-2:0]    slew,
    input  logic            cnt_clr,
    output logic            out_valid,
    output logic [N*W-1:0]  out_data,
    output logic [N-1:0]    sat_flag,
    output logic [N*CW-1:0] sat_cnt
);

    // The exponent only documents the code scaling; nothing inside depends on it.
    if (EXP < -1024 || EXP > 1024) begin : g_exp_range
        $error("EXP outside supported range");
    end

    logic            out_valid_q, out_valid_d;
    logic [N*W-1:0]  out_data_q, out_data_d;
    logic [N-1:0]    sat_flag_q, sat_flag_d;
    logic [N*CW-1:0] sat_cnt_q, sat_cnt_d;
    logic            primed_q, primed_d;

    logic signed [W-1:0] lo_s, hi_s;
    logic signed [W:0]   slew_pos, slew_neg;
    logic [W-1:0]        slew_w;

    logic [W-1:0] res_w [N];
    logic [N-1:0] ev_w;

    assign lo_s     = lo;
    assign hi_s     = hi;
    assign slew_pos = {2'b00, slew};
    assign slew_neg = -slew_pos;
    assign slew_w   = {1'b0, slew};

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic signed [W-1:0] x, prev, lo_c, c, res;
        logic signed [W:0]   d;
        logic                ev;

        assign x    = in_data[i*W +: W];
        assign prev = out_data_q[i*W +: W];

        always_comb begin
            // max against lo first, then min against hi: an inverted window yields hi
            lo_c = (x < lo_s) ? lo_s : x;
            c    = (lo_c > hi_s) ? hi_s : lo_c;
            d    = {c[W-1], c} - {prev[W-1], prev};
            ev   = in_valid && (mode != 2'b00) && ((x < lo_s) || (x > hi_s));
            res  = c;
            case (mode)
                2'b00:   res = x;
                2'b01:   res = c;
                default: begin
                    if (!primed_q) begin
                        res = c;
                    end else if (d > slew_pos) begin
                        res = prev + slew_w;
                    end else if (d < slew_neg) begin
                        res = prev - slew_w;
                    end else begin
                        res = c;
                    end
                end
            endcase
        end

        assign res_w[i] = res;
        assign ev_w[i]  = ev;
    end

    always_comb begin
        out_valid_d = in_valid;
        primed_d    = primed_q | in_valid;
        out_data_d  = out_data_q;
        sat_cnt_d   = sat_cnt_q;
        sat_flag_d  = sat_flag_q;
        for (int i = 0; i < N; i++) begin
            if (in_valid) begin
                out_data_d[i*W +: W] = res_w[i];
            end
            // clear wins over a same-cycle clamp event
            if (cnt_clr) begin
                sat_cnt_d[i*CW +: CW] = '0;
                sat_flag_d[i]         = 1'b0;
            end else if (ev_w[i]) begin
                sat_flag_d[i] = 1'b1;
                if (sat_cnt_q[i*CW +: CW] != {CW{1'b1}}) begin
                    sat_cnt_d[i*CW +: CW] = sat_cnt_q[i*CW +: CW] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= '0;
            sat_cnt_q   <= '0;
            primed_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_flag_d;
            sat_cnt_q   <= sat_cnt_d;
            primed_q    <= primed_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_clamp_slew_mc.sv
// Scoreboard bench for clamp_slew_mc: stimulus queues expected out_data, a negedge monitor
// pops and compares whenever out_valid is high; counters/flags are checked at quiet points.
module tb_clamp_slew_mc;
    localparam int N  = 2;
    localparam int W  = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [N*W-1:0]  in_data;
    logic [1:0]      mode;
    logic [W-1:0]    lo, hi;
    logic [W-2:0]    slew;
    logic            cnt_clr;
    logic            out_valid;
    logic [N*W-1:0]  out_data;
    logic [N-1:0]    sat_flag;
    logic [N*CW-1:0] sat_cnt;

    int total = 0;
    int bad   = 0;
    logic [N*W-1:0] exp_q [$];

    clamp_slew_mc #(.N(N), .W(W), .EXP(-8), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .slew     (slew),
        .cnt_clr  (cnt_clr),
        .out_valid(out_valid),
        .out_data (out_data),
        .sat_flag (sat_flag),
        .sat_cnt  (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic set_bounds(input int l, input int h);
        logic [31:0] lv, hv;
        lv = l;
        hv = h;
        lo = lv[W-1:0];
        hi = hv[W-1:0];
    endtask

    task automatic send(input int x0, input int x1, input int e0, input int e1);
        logic [31:0] a0, a1, b0, b1;
        a0 = x0; a1 = x1; b0 = e0; b1 = e1;
        in_valid = 1'b1;
        in_data  = {a1[W-1:0], a0[W-1:0]};
        exp_q.push_back({b1[W-1:0], b0[W-1:0]});
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
    endtask

    // Monitor: every presented output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h want no output", out_data);
            end else begin
                check("out_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        mode     = 2'b01;
        slew     = '0;
        cnt_clr  = 1'b0;
        set_bounds(-640, 640);
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_sat_flag", {62'd0, sat_flag}, 64'd0);
        check("rst_sat_cnt", {56'd0, sat_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        // 1: clamp sweep on ch0, ch1 idle at 0
        send(-1024, 0, -640, 0);
        send(-768, 0, -640, 0);
        send(-512, 0, -512, 0);
        send(0, 0, 0, 0);
        send(512, 0, 512, 0);
        send(768, 0, 640, 0);
        send(1024, 0, 640, 0);
        idle(2);
        check("t1_cnt0", {60'd0, sat_cnt[3:0]}, 64'd4);
        check("t1_flag0", {63'd0, sat_flag[0]}, 64'd1);
        check("t1_cnt1", {60'd0, sat_cnt[7:4]}, 64'd0);
        check("t1_flag1", {63'd0, sat_flag[1]}, 64'd0);
        clear_counters();
        check("t1_clr_cnt", {56'd0, sat_cnt}, 64'd0);
        check("t1_clr_flag", {62'd0, sat_flag}, 64'd0);

        // 2: slew ramp up and back down
        send(0, 0, 0, 0);
        mode = 2'b10;
        set_bounds(-2048, 2048);
        slew = 15'd100;
        for (int k = 1; k <= 12; k++) send(1000, 0, (k > 10) ? 1000 : k * 100, 0);
        for (int k = 1; k <= 10; k++) send(-50, 0, 1000 - k * 100, 0);
        send(-50, 0, -50, 0);
        send(-50, 0, -50, 0);
        idle(2);
        check("t2_cnt", {56'd0, sat_cnt}, 64'd0);

        // 3: inverted bounds resolve to hi and count on both channels
        mode = 2'b01;
        set_bounds(300, -300);
        send(0, 0, -300, -300);
        idle(2);
        check("t3_cnt0", {60'd0, sat_cnt[3:0]}, 64'd1);
        check("t3_cnt1", {60'd0, sat_cnt[7:4]}, 64'd1);
        check("t3_flags", {62'd0, sat_flag}, 64'd3);

        // 4: counter saturation, then clear colliding with a clamp event
        clear_counters();
        set_bounds(-640, 640);
        for (int k = 0; k < 20; k++) send(1000, 0, 640, 0);
        idle(2);
        check("t4_cnt0_sat", {60'd0, sat_cnt[3:0]}, 64'd15);
        check("t4_cnt1", {60'd0, sat_cnt[7:4]}, 64'd0);
        check("t4_flags", {62'd0, sat_flag}, 64'd1);
        cnt_clr = 1'b1;
        send(1000, 0, 640, 0);
        idle(1);
        check("t4_clr_cnt", {56'd0, sat_cnt}, 64'd0);
        check("t4_clr_flag", {62'd0, sat_flag}, 64'd0);

        // 5: bypass ignores bounds, then slew from the bypassed value
        mode = 2'b00;
        set_bounds(-640, 100);
        send(5000, 0, 5000, 0);
        idle(1);
        check("t5_bypass_cnt", {56'd0, sat_cnt}, 64'd0);
        mode = 2'b10;
        slew = 15'd1000;
        send(5000, 0, 4000, 0);
        idle(1);
        check("t5_cnt0", {60'd0, sat_cnt[3:0]}, 64'd1);
        check("t5_flag0", {63'd0, sat_flag[0]}, 64'd1);

        // 6: gaps hold output, async reset mid-slew, unprimed first sample after release
        mode = 2'b01;
        set_bounds(-2048, 2048);
        send(0, 0, 0, 0);
        mode = 2'b11;
        slew = 15'd100;
        send(500, 0, 100, 0);
        idle(3);
        check("t6_gap_valid", {63'd0, out_valid}, 64'd0);
        check("t6_gap_hold", {48'd0, out_data[15:0]}, 64'd100);
        send(500, 0, 200, 0);
        idle(1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_data", {32'd0, out_data}, 64'd0);
        check("t6_rst_cnt", {56'd0, sat_cnt}, 64'd0);
        check("t6_rst_flag", {62'd0, sat_flag}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        send(1500, 0, 1500, 0);
        send(0, 0, 1400, 0);
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
